regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of the write port.
REQ-002 SHALL have parameter AWIDTH, default 5: register address width (32 registers).
REQ-003 SHALL use one clock and an asynchronous, active-low reset: Clk input 1, rising-edge clock; Rst_n input 1, asynchronous active-low reset.
REQ-004 SHALL have ValidA input 1: write request from requester A (ALU write-back).
REQ-005 SHALL have AddrA input AWIDTH and DataA input WIDTH: requester A destination register and data.
REQ-006 SHALL have ValidB input 1: write request from requester B (load write-back).
REQ-007 SHALL have AddrB input AWIDTH and DataB input WIDTH: requester B destination register and data.
REQ-008 SHALL have Hold input 1: when high, no new grant is issued.
REQ-009 SHALL have GntA and GntB outputs 1: request accepted this cycle (combinational).
REQ-010 SHALL have RegWrite output 1, WriteRegister output AWIDTH and WriteData output WIDTH, all registered: drive the register-file write port.
REQ-011 SHALL have ReadRegister1 and ReadRegister2 inputs AWIDTH: register-file read addresses being probed.
REQ-012 SHALL have Pending1 and Pending2 outputs 1: the probed register has an accepted write not yet committed.

Function
REQ-013 SHALL issue at most one grant per cycle; GntA and GntB are never both high.
REQ-014 SHALL issue a grant only when Hold=0 and Rst_n=1; with Hold=1, both grants SHALL be 0 and requests SHALL be left pending.
REQ-015 SHALL grant the single valid requester when only one of ValidA/ValidB is high.
REQ-016 SHALL use round-robin arbitration when both are valid: grant the requester not granted last; a 1-bit LastB register updates only on a grant (1 = B last).
REQ-017 SHALL treat a requester as holding its Addr/Data stable while its Valid is high and its grant is 0; the request SHALL be dropped by the requester in the cycle after its grant.
REQ-018 SHALL, on a grant in cycle N, capture the winner's Addr/Data into WriteRegister/WriteData at the edge ending N and set RegWrite=1 for cycle N+1 only, giving one-cycle latency; the register file commits at the edge ending N+1.
REQ-019 SHALL assert the grant for a write to address 0, but RegWrite SHALL stay 0 in N+1; WriteRegister/WriteData still update.
REQ-020 SHALL sustain back-to-back grants: one write per cycle, with RegWrite staying high across consecutive accepted writes.
REQ-021 SHALL hold WriteRegister/WriteData at their last values when RegWrite=0 after a write.
REQ-022 SHALL assert Pending1 combinationally when RegWrite=1, WriteRegister==ReadRegister1 and WriteRegister!=0; Pending2 likewise for ReadRegister2.
REQ-023 SHALL let a grant and the RegWrite of the previous grant coexist in the same cycle, with no interaction between them.
REQ-024 SHALL, when Hold rises while RegWrite=1, still complete the in-flight write; only new grants are blocked.

Reset
REQ-025 SHALL, while Rst_n=0, immediately force RegWrite=0, WriteRegister=0, WriteData=0, LastB=1 (so A wins the first tie), and GntA=GntB=0, regardless of Clk.
REQ-026 SHALL discard an in-flight write when reset is asserted mid-operation; no RegWrite pulse occurs after Rst_n deasserts until a new grant.
REQ-027 SHALL issue the first grant in the first cycle after Rst_n deasserts if a request is valid.

Verification
REQ-028 Bench SHALL apply reset, then ValidA=1, AddrA=5, DataA=0xDEADBEEF, and require GntA=1 in cycle N, then RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF in N+1, then RegWrite=0 in N+2.
REQ-029 Bench SHALL hold both requesters valid continuously for 4 cycles after reset and require the grant sequence A,B,A,B with RegWrite high for 4 consecutive cycles.
REQ-030 Bench SHALL apply ValidB=1, AddrB=0, DataB=0x1234, and require GntB=1 with RegWrite=0 in the next cycle, and Pending1=0 with ReadRegister1=0.
REQ-031 Bench SHALL apply Hold=1 with ValidA=1 for 3 cycles and require no grant; after Hold=0, GntA=1 in the same cycle.
REQ-032 Bench SHALL grant A to register 29, with ReadRegister2=29 in N+1, and require Pending2=1 in N+1 and Pending2=0 in N+2.
REQ-033 Bench SHALL assert Rst_n=0 mid-cycle during N+1 of a write and require RegWrite=0 immediately, with no RegWrite pulse after release.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester round-robin write arbiter driving a register-file write port
module regfile_write_arbiter #(
    parameter int WIDTH  = 32,
    parameter int AWIDTH = 5
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              ValidA,
    input  logic [AWIDTH-1:0] AddrA,
    input  logic [WIDTH-1:0]  DataA,
    input  logic              ValidB,
    input  logic [AWIDTH-1:0] AddrB,
    input  logic [WIDTH-1:0]  DataB,
    input  logic              Hold,
    output logic              GntA,
    output logic              GntB,
    output logic              RegWrite,
    output logic [AWIDTH-1:0] WriteRegister,
    output logic [WIDTH-1:0]  WriteData,
    input  logic [AWIDTH-1:0] ReadRegister1,
    input  logic [AWIDTH-1:0] ReadRegister2,
    output logic              Pending1,
    output logic              Pending2
);

    logic lastB;
    logic grantA;
    logic grantB;

    // On a tie the requester not granted last wins; Rst_n gates grants so reset is immediate.
    always_comb begin
        grantA = 1'b0;
        grantB = 1'b0;
        if (Rst_n && !Hold) begin
            if (ValidA && (!ValidB || lastB)) begin
                grantA = 1'b1;
            end else if (ValidB) begin
                grantB = 1'b1;
            end
        end
    end

    assign GntA = grantA;
    assign GntB = grantB;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            lastB         <= 1'b1;
        end else begin
            RegWrite <= 1'b0;
            if (grantA) begin
                WriteRegister <= AddrA;
                WriteData     <= DataA;
                RegWrite      <= (AddrA != '0);
                lastB         <= 1'b0;
            end else if (grantB) begin
                WriteRegister <= AddrB;
                WriteData     <= DataB;
                RegWrite      <= (AddrB != '0);
                lastB         <= 1'b1;
            end
        end
    end

    // Register 0 is hardwired, so it can never be a pending write target.
    assign Pending1 = RegWrite && (WriteRegister == ReadRegister1) && (WriteRegister != '0);
    assign Pending2 = RegWrite && (WriteRegister == ReadRegister2) && (WriteRegister != '0);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    localparam int WIDTH  = 32;
    localparam int AWIDTH = 5;

    logic              Clk;
    logic              Rst_n;
    logic              ValidA;
    logic [AWIDTH-1:0] AddrA;
    logic [WIDTH-1:0]  DataA;
    logic              ValidB;
    logic [AWIDTH-1:0] AddrB;
    logic [WIDTH-1:0]  DataB;
    logic              Hold;
    logic              GntA;
    logic              GntB;
    logic              RegWrite;
    logic [AWIDTH-1:0] WriteRegister;
    logic [WIDTH-1:0]  WriteData;
    logic [AWIDTH-1:0] ReadRegister1;
    logic [AWIDTH-1:0] ReadRegister2;
    logic              Pending1;
    logic              Pending2;

    regfile_write_arbiter #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .ValidA(ValidA), .AddrA(AddrA), .DataA(DataA),
        .ValidB(ValidB), .AddrB(AddrB), .DataB(DataB),
        .Hold(Hold), .GntA(GntA), .GntB(GntB),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .Pending1(Pending1), .Pending2(Pending2)
    );

    typedef struct {
        bit                isB;
        logic [AWIDTH-1:0] addr;
        logic [WIDTH-1:0]  data;
    } write_t;

    write_t expQ[$];
    int checks = 0;
    int failures = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushExp(input bit isB, input logic [AWIDTH-1:0] addr, input logic [WIDTH-1:0] data);
        write_t w;
        w.isB  = isB;
        w.addr = addr;
        w.data = data;
        expQ.push_back(w);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every grant and checks the write port one cycle later.
    bit                prevValid = 1'b0;
    logic [AWIDTH-1:0] prevAddr;
    logic [WIDTH-1:0]  prevData;

    always @(negedge Clk) begin
        if (!Rst_n) begin
            check("reset_regwrite", {31'd0, RegWrite}, 32'd0);
            check("reset_grants", {30'd0, GntA, GntB}, 32'd0);
            prevValid = 1'b0;
        end else begin
            check("regwrite", {31'd0, RegWrite}, {31'd0, (prevValid && prevAddr != '0)});
            if (prevValid) begin
                check("write_register", {27'd0, WriteRegister}, {27'd0, prevAddr});
                check("write_data", WriteData, prevData);
            end
            check("one_hot_grant", {31'd0, (GntA && GntB)}, 32'd0);
            prevValid = 1'b0;
            if (GntA || GntB) begin
                if (expQ.size() == 0) begin
                    check("unexpected_grant", {30'd0, GntA, GntB}, 32'd0);
                end else begin
                    write_t w;
                    w = expQ.pop_front();
                    check("grant_b", {31'd0, GntB}, {31'd0, w.isB});
                    prevValid = 1'b1;
                    prevAddr  = w.addr;
                    prevData  = w.data;
                end
            end
        end
    end

    task automatic resetDut();
        Rst_n  = 1'b0;
        ValidA = 1'b0;
        ValidB = 1'b0;
        Hold   = 1'b0;
        step();
        step();
        Rst_n = 1'b1;
    endtask

    // Back-to-back tie vectors: A addr/data, B addr/data, hand-computed winner
    logic [AWIDTH-1:0] tAddrA [4] = '{5'd1, 5'd3, 5'd3, 5'd5};
    logic [WIDTH-1:0]  tDataA [4] = '{32'h11, 32'h33, 32'h33, 32'h55};
    logic [AWIDTH-1:0] tAddrB [4] = '{5'd2, 5'd2, 5'd4, 5'd4};
    logic [WIDTH-1:0]  tDataB [4] = '{32'h22, 32'h22, 32'h44, 32'h44};
    bit                tWinB  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        Rst_n = 1'b0;
        ValidA = 1'b1;
        ValidB = 1'b1;
        AddrA = 5'd3;
        DataA = 32'hAAAA;
        AddrB = 5'd4;
        DataB = 32'hBBBB;
        Hold = 1'b0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        #3;
        check("rst_gnt_a", {31'd0, GntA}, 32'd0);
        check("rst_gnt_b", {31'd0, GntB}, 32'd0);
        check("rst_write_register", {27'd0, WriteRegister}, 32'd0);
        check("rst_write_data", WriteData, 32'd0);
        check("rst_regwrite", {31'd0, RegWrite}, 32'd0);

        // Single A write, granted in the first cycle after reset release
        resetDut();
        ValidA = 1'b1; AddrA = 5'd5; DataA = 32'hDEADBEEF;
        pushExp(1'b0, 5'd5, 32'hDEADBEEF);
        step();
        ValidA = 1'b0;
        step();
        step();

        // Continuous tie after reset: A,B,A,B with RegWrite held high
        resetDut();
        for (int k = 0; k < 4; k++) begin
            ValidA = 1'b1; AddrA = tAddrA[k]; DataA = tDataA[k];
            ValidB = 1'b1; AddrB = tAddrB[k]; DataB = tDataB[k];
            pushExp(tWinB[k], tWinB[k] ? tAddrB[k] : tAddrA[k], tWinB[k] ? tDataB[k] : tDataA[k]);
            step();
        end
        ValidA = 1'b0;
        ValidB = 1'b0;
        step();
        step();

        // Write to register 0: granted, no RegWrite, no pending
        ValidB = 1'b1; AddrB = 5'd0; DataB = 32'h1234; ReadRegister1 = 5'd0;
        pushExp(1'b1, 5'd0, 32'h1234);
        step();
        ValidB = 1'b0;
        @(negedge Clk);
        check("pending1_reg0", {31'd0, Pending1}, 32'd0);
        step();

        // Hold rises during an in-flight write and blocks new grants for 3 cycles
        ValidA = 1'b1; AddrA = 5'd6; DataA = 32'h66;
        pushExp(1'b0, 5'd6, 32'h66);
        step();
        Hold = 1'b1; AddrA = 5'd7; DataA = 32'h77;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            check("hold_gnt_a", {31'd0, GntA}, 32'd0);
            check("hold_gnt_b", {31'd0, GntB}, 32'd0);
            step();
        end
        Hold = 1'b0;
        pushExp(1'b0, 5'd7, 32'h77);
        @(negedge Clk);
        check("release_gnt_a", {31'd0, GntA}, 32'd1);
        step();
        ValidA = 1'b0;
        step();
        step();

        // Pending2 on the in-flight write to register 29
        ValidA = 1'b1; AddrA = 5'd29; DataA = 32'h2929;
        pushExp(1'b0, 5'd29, 32'h2929);
        step();
        ValidA = 1'b0; ReadRegister2 = 5'd29;
        @(negedge Clk);
        check("pending2_n1", {31'd0, Pending2}, 32'd1);
        step();
        @(negedge Clk);
        check("pending2_n2", {31'd0, Pending2}, 32'd0);
        step();

        // Reset mid-cycle during N+1 discards the in-flight write
        ValidA = 1'b1; AddrA = 5'd9; DataA = 32'h99;
        pushExp(1'b0, 5'd9, 32'h99);
        step();
        ValidA = 1'b0;
        #1;
        check("inflight_regwrite", {31'd0, RegWrite}, 32'd1);
        Rst_n = 1'b0;
        #1;
        check("async_rst_regwrite", {31'd0, RegWrite}, 32'd0);
        check("async_rst_write_register", {27'd0, WriteRegister}, 32'd0);
        check("async_rst_write_data", WriteData, 32'd0);
        step();
        step();
        Rst_n = 1'b1;
        step();
        step();
        step();

        check("scoreboard_empty", expQ.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
